// File: rtl/frame_dispatch_sel.sv
// Frame dispatcher: latches a destination from each SOP header, waits for the target FIFO(s),
// then forwards the frame with zero latency or drops it on timeout.
// Optional broadcast on header bit 7 is enabled by defining FRAME_DISPATCH_BCAST_EN.
module frame_dispatch_sel #(
    parameter int unsigned PORT_NUM = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_sop,
    input  logic                in_eop,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    input  logic [PORT_NUM-1:0] fifo_full,
    output logic [PORT_NUM-1:0] bus_sel,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_sop,
    output logic                out_eop,
    output logic [15:0]         drop_cnt
);

    localparam int unsigned DEST_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StFwd, StDrop} state_t;

    state_t              r_state;
    logic [PORT_NUM-1:0] r_bus_sel;
    logic                r_bad_dest;
    logic [7:0]          r_wait_cnt;
    logic [15:0]         r_drop_cnt;

    logic [DEST_W-1:0]   w_dest;
    logic                w_bad_dest;
    logic                w_bcast;
    logic [PORT_NUM-1:0] w_mask;
    logic                w_blocked;
    logic                w_to_hit;
    logic                w_in_ready;
    logic                w_out_valid;

    assign w_dest     = in_data[DEST_W-1:0];
    assign w_bad_dest = (32'(w_dest) >= PORT_NUM);

`ifdef FRAME_DISPATCH_BCAST_EN
    assign w_bcast = in_data[7];
`else
    assign w_bcast = 1'b0;
`endif

    // An out-of-range destination shifts out to an empty mask; r_bad_dest sends it to DROP.
    assign w_mask    = w_bcast ? {PORT_NUM{1'b1}} : (PORT_NUM'(1) << w_dest);
    assign w_blocked = |(fifo_full & r_bus_sel);
    assign w_to_hit  = (({1'b0, r_wait_cnt} + 9'd1) >= 9'(TIMEOUT));

    always_comb begin
        w_in_ready = 1'b0;
        unique case (r_state)
            StIdle: w_in_ready = in_valid && !in_sop;
            StWait: w_in_ready = 1'b0;
            StFwd:  w_in_ready = !w_blocked;
            StDrop: w_in_ready = 1'b1;
            default: w_in_ready = 1'b0;
        endcase
        if (rst) begin
            w_in_ready = 1'b0;
        end
    end

    assign w_out_valid = (r_state == StFwd) && in_valid && w_in_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? in_data : '0;
    assign out_sop   = w_out_valid && in_sop;
    assign out_eop   = w_out_valid && in_eop;
    assign bus_sel   = r_bus_sel;
    assign drop_cnt  = r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_bus_sel  <= '0;
            r_bad_dest <= 1'b0;
            r_wait_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    // The SOP beat is only inspected here; it stays on the bus until FWD/DROP.
                    if (in_valid && in_sop) begin
                        r_bus_sel  <= w_mask;
                        r_bad_dest <= !w_bcast && w_bad_dest;
                        r_wait_cnt <= '0;
                        r_state    <= StWait;
                    end
                end
                StWait: begin
                    if (!r_bad_dest && !w_blocked) begin
                        r_state <= StFwd;
                    end else if (r_bad_dest || w_to_hit) begin
                        r_state   <= StDrop;
                        r_bus_sel <= '0;
                        if (r_drop_cnt != 16'hFFFF) begin
                            r_drop_cnt <= r_drop_cnt + 16'd1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                StFwd: begin
                    if (w_out_valid && in_eop) begin
                        r_state   <= StIdle;
                        r_bus_sel <= '0;
                    end
                end
                StDrop: begin
                    if (in_valid && in_eop) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_dispatch_sel.sv
// Bench for frame_dispatch_sel: directed scenarios plus random traffic, run on two instances
// (TIMEOUT 255 and 4) against a cycle-level reference model of the dispatch rules.
module tb_frame_dispatch_sel;

    localparam int ToA = 255;
    localparam int ToB = 4;
`ifdef FRAME_DISPATCH_BCAST_EN
    localparam bit Bcast = 1'b1;
`else
    localparam bit Bcast = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_sop, in_eop;
    logic [7:0] in_data;
    logic [3:0] fifo_full;

    logic       rdy_a, ov_a, os_a, oe_a, rdy_b, ov_b, os_b, oe_b;
    logic [3:0] sel_a, sel_b;
    logic [7:0] od_a, od_b;
    logic [15:0] dc_a, dc_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Phases: 0 idle, 1 waiting for room, 2 forwarding, 3 dropping.
    typedef struct {
        int ph;
        int mask;
        int waited;
        int drops;
    } mdl_t;

    typedef struct packed {
        logic        rdy;
        logic [3:0]  sel;
        logic        ov;
        logic [7:0]  od;
        logic        os;
        logic        oe;
        logic [15:0] dc;
    } exp_t;

    mdl_t m [2];

    always #5 clk = ~clk;

    frame_dispatch_sel #(.PORT_NUM(4), .DATA_W(8), .TIMEOUT(ToA)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_data(in_data), .in_ready(rdy_a), .fifo_full(fifo_full), .bus_sel(sel_a),
        .out_valid(ov_a), .out_data(od_a), .out_sop(os_a), .out_eop(oe_a), .drop_cnt(dc_a)
    );

    frame_dispatch_sel #(.PORT_NUM(4), .DATA_W(8), .TIMEOUT(ToB)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_data(in_data), .in_ready(rdy_b), .fifo_full(fifo_full), .bus_sel(sel_b),
        .out_valid(ov_b), .out_data(od_b), .out_sop(os_b), .out_eop(oe_b), .drop_cnt(dc_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.ph = 0; r.mask = 0; r.waited = 0; r.drops = 0;
        return r;
    endfunction

    function automatic exp_t model_out(input mdl_t st);
        exp_t x;
        int   room;
        x = '0;
        if (rst) return x;
        room = ((int'(fifo_full) & st.mask) == 0);
        case (st.ph)
            0: x.rdy = in_valid && !in_sop;
            1: x.sel = 4'(st.mask);
            2: begin x.sel = 4'(st.mask); x.rdy = (room != 0); end
            default: x.rdy = 1'b1;
        endcase
        x.ov = (st.ph == 2) && in_valid && x.rdy;
        if (x.ov) begin
            x.od = in_data; x.os = in_sop; x.oe = in_eop;
        end
        x.dc = 16'(st.drops);
        return x;
    endfunction

    function automatic mdl_t model_next(input mdl_t st, input int to);
        mdl_t n;
        bit   bc;
        n = st;
        if (rst) return mdl_reset();
        case (st.ph)
            0: if (in_valid && in_sop) begin
                bc = Bcast && in_data[7];
                n.mask = bc ? 15 : (1 << in_data[1:0]);
                n.ph = 1;
                n.waited = 0;
            end
            1: if ((int'(fifo_full) & st.mask) == 0) begin
                n.ph = 2;
            end else begin
                n.waited = st.waited + 1;
                if (n.waited >= to) begin
                    n.ph = 3;
                    if (st.drops < 65535) n.drops = st.drops + 1;
                end
            end
            2: if (in_valid && in_eop && ((int'(fifo_full) & st.mask) == 0)) n.ph = 0;
            default: if (in_valid && in_eop) n.ph = 0;
        endcase
        return n;
    endfunction

    task automatic check_all();
        exp_t  x, act;
        string dn;
        for (int k = 0; k < 2; k++) begin
            x   = model_out(m[k]);
            act = (k == 0) ? {rdy_a, sel_a, ov_a, od_a, os_a, oe_a, dc_a}
                           : {rdy_b, sel_b, ov_b, od_b, os_b, oe_b, dc_b};
            dn  = (k == 0) ? "A" : "B";
            check_eq({dn, "_in_ready"}, 32'(act.rdy), 32'(x.rdy));
            check_eq({dn, "_bus_sel"},  32'(act.sel), 32'(x.sel));
            check_eq({dn, "_out_valid"}, 32'(act.ov), 32'(x.ov));
            check_eq({dn, "_out_data"}, 32'(act.od), 32'(x.od));
            check_eq({dn, "_out_sop"},  32'(act.os), 32'(x.os));
            check_eq({dn, "_out_eop"},  32'(act.oe), 32'(x.oe));
            check_eq({dn, "_drop_cnt"}, 32'(act.dc), 32'(x.dc));
        end
    endtask

    // Drives one cycle's inputs just after the edge and checks outputs before the next edge.
    task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d,
                         input logic [3:0] f, input logic r);
        in_valid = v; in_sop = s; in_eop = e; in_data = d; fifo_full = f; rst = r;
        if (r) begin
            m[0] = mdl_reset();
            m[1] = mdl_reset();
        end
        #4;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        m[0] = model_next(m[0], ToA);
        m[1] = model_next(m[1], ToB);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        tick();
    endtask

    logic [7:0] bp_data [4];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_data = 8'h00; fifo_full = 4'h0;
        m[0] = mdl_reset();
        m[1] = mdl_reset();
        @(posedge clk);
        #1;

        // Reset state
        drive(1'b1, 1'b0, 1'b0, 8'h5A, 4'h0, 1'b1);
        check_eq("rst_in_ready", 32'(rdy_a), 32'd0);
        check_eq("rst_out_data", 32'(od_a), 32'd0);
        tick();

        // Unicast 3-beat frame to port 2
        drive(1'b1, 1'b1, 1'b0, 8'h02, 4'h0, 1'b0);
        check_eq("uni_idle_ready", 32'(rdy_a), 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h02, 4'h0, 1'b0);
        check_eq("uni_wait_sel", 32'(sel_a), 32'b0100);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h02, 4'h0, 1'b0);
        check_eq("uni_b1_valid", 32'(ov_a), 32'd1);
        check_eq("uni_b1_sop", 32'(os_a), 32'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h55, 4'h0, 1'b0);
        check_eq("uni_b2_data", 32'(od_a), 32'h55);
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'hAA, 4'h0, 1'b0);
        check_eq("uni_b3_eop", 32'(oe_a), 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
        check_eq("uni_idle_sel", 32'(sel_a), 32'd0);
        tick();

        // Backpressure on port 1 for 5 cycles, then a 4-beat frame
        bp_data[0] = 8'h01; bp_data[1] = 8'h11; bp_data[2] = 8'h22; bp_data[3] = 8'h33;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'h01, 4'b0010, 1'b0);
            check_eq("bp_ready", 32'(rdy_a), 32'd0);
            check_eq("bp_valid", 32'(ov_a), 32'd0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 8'h01, 4'h0, 1'b0);
        check_eq("bp_release_sel", 32'(sel_a), 32'b0010);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0), (i == 3), bp_data[i], 4'h0, 1'b0);
            check_eq("bp_fwd_valid", 32'(ov_a), 32'd1);
            check_eq("bp_fwd_data", 32'(od_a), 32'(bp_data[i]));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
        tick();

        // Timeout on port 3 (instance B, TIMEOUT=4)
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 8'h03, 4'b1000, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'h03, 4'b1000, 1'b0);
            check_eq("to_wait_sel", 32'(sel_b), 32'b1000);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, (i == 0), (i == 2), 8'h03 + 8'(i), 4'b1000, 1'b0);
            check_eq("to_drop_ready", 32'(rdy_b), 32'd1);
            check_eq("to_drop_valid", 32'(ov_b), 32'd0);
            check_eq("to_drop_cnt", 32'(dc_b), 32'd1);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
        check_eq("to_idle_sel", 32'(sel_b), 32'd0);
        tick();

        // Reset in FWD after 2 of 4 beats, then a frame to port 0
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 8'h02, 4'h0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 8'h02, 4'h0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 8'h02, 4'h0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, 8'h44, 4'h0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, 8'h45, 4'h0, 1'b1);
        check_eq("rfwd_sel", 32'(sel_a), 32'd0);
        check_eq("rfwd_valid", 32'(ov_a), 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0);
        check_eq("rfwd_next_sel", 32'(sel_a), 32'b0001);
        check_eq("rfwd_next_valid", 32'(ov_a), 32'd1);
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'h99, 4'h0, 1'b0);
        check_eq("rfwd_next_eop", 32'(oe_a), 32'd1);
        tick();

`ifdef FRAME_DISPATCH_BCAST_EN
        // Broadcast header stalls while any FIFO is full
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 8'h80, 4'b0100, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'h80, 4'b0100, 1'b0);
            check_eq("bc_sel", 32'(sel_a), 32'b1111);
            check_eq("bc_stall", 32'(ov_a), 32'd0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 8'h80, 4'h0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b1, 8'h80, 4'h0, 1'b0);
        check_eq("bc_fwd", 32'(ov_a), 32'd1);
        tick();
`endif

        // Stray beats in IDLE
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, (i == 2), 8'h70 + 8'(i), 4'h0, 1'b0);
            check_eq("stray_ready", 32'(rdy_a), 32'd1);
            check_eq("stray_valid", 32'(ov_a), 32'd0);
            check_eq("stray_drops", 32'(dc_a), 32'd0);
            tick();
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 3) == 0,
                  8'($urandom), (($urandom % 4) == 0) ? 4'($urandom) : 4'h0,
                  ($urandom_range(0, 299) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_dispatch_sel.md
FRAME_DISPATCH_SEL -- requirements
Module: frame_dispatch_sel

Interface
REQ-001 Parameter PORT_NUM, default 4, number of output FIFOs, and width of bus_sel.
REQ-002 Parameter DATA_W, default 8, data byte width; minimum 8.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before a frame is dropped; range 1..255.
REQ-004 clk  input  1  single block clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream beat valid.
REQ-007 in_sop  input  1  start-of-frame flag; qualified by in_valid.
REQ-008 in_eop  input  1  end-of-frame flag; qualified by in_valid.
REQ-009 in_data  input  DATA_W  beat data; on an SOP beat, bits [log2(PORT_NUM)-1:0] hold the destination port and bit 7 holds the broadcast flag.
REQ-010 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-011 fifo_full  input  PORT_NUM  per-destination FIFO full flags.
REQ-012 bus_sel  output  PORT_NUM  this dispatcher's per-FIFO select bits; feeds the bus-select interconnect as one fd_x_bus_sel vector.
REQ-013 out_valid  output  1  forwarded beat valid.
REQ-014 out_data  output  DATA_W  forwarded beat data.
REQ-015 out_sop  output  1  forwarded SOP flag.
REQ-016 out_eop  output  1  forwarded EOP flag.
REQ-017 drop_cnt  output  16  saturating count of frames dropped on timeout.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, FWD and DROP.
- Encoding is free.
- Current state is not an output.
REQ-019 IDLE SHALL behave as follows:
- bus_sel=0 and out_valid=0.
- in_ready=1 only when in_valid && !in_sop; such stray beats are discarded and not counted.
- in_valid && in_sop latches the destination and broadcast flag without consuming the beat, then moves to WAIT.
REQ-020 WAIT SHALL behave as follows:
- in_ready=0.
- bus_sel is one-hot of the latched destination.
- Moves to FWD in the cycle after the target mask is not full: unicast needs fifo_full[dest]=0; broadcast needs fifo_full all zero.
- Otherwise the wait counter increments.
- When the wait counter reaches TIMEOUT, the next state is DROP.
REQ-021 FWD SHALL behave as follows:
- bus_sel is held.
- in_ready is the negation of the OR of fifo_full over the bus_sel mask.
- Zero latency: out_valid = in_valid && in_ready, and out_data/out_sop/out_eop = in_data/in_sop/in_eop.
- An accepted beat with in_eop returns to IDLE in the next cycle.
- The SOP beat is the first beat forwarded.
REQ-022 A beat with in_sop=1 arriving mid-frame in FWD SHALL be forwarded as ordinary data with out_sop=1; the FSM does not restart.
REQ-023 DROP SHALL behave as follows:
- bus_sel=0, out_valid=0, in_ready=1.
- Beats are discarded.
- The accepted EOP beat returns the FSM to IDLE.
- drop_cnt increments by 1 on entry to DROP and saturates at 16'hFFFF.
REQ-024 A single-beat frame (in_sop && in_eop) SHALL complete in FWD in one accepted cycle.
REQ-025 The wait counter SHALL be 8 bits and clear on every entry to WAIT.
REQ-026 A destination index >= PORT_NUM SHALL be treated as a timeout immediately: WAIT lasts 1 cycle, then DROP.
REQ-027 If fifo_full deasserts in the same cycle the counter reaches TIMEOUT, the FSM SHALL go to FWD.

Reset
REQ-028 While rst=1, the block SHALL be held as follows:
- State is IDLE; wait counter and drop_cnt are 0.
- bus_sel=0, in_ready=0, out_valid=0, out_sop=0, out_eop=0, out_data=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no out_eop generated; after release, the block resynchronises on the next in_sop.

Configuration
REQ-030 When FRAME_DISPATCH_BCAST_EN is defined, an SOP beat with in_data[7]=1 SHALL set bus_sel to all ones and ignore the destination field.
REQ-031 When FRAME_DISPATCH_BCAST_EN is undefined, in_data[7] SHALL be ignored and only unicast is supported.

Verification
REQ-032 The bench SHALL cover these directed scenarios (PORT_NUM=4, TIMEOUT=255):
- Unicast: 3-beat frame, header 8'h02, fifo_full=0 -> bus_sel=4'b0100 from the WAIT cycle; 3 out_valid beats in consecutive cycles; IDLE after EOP.
- Backpressure: fifo_full[1] asserted for 5 cycles on a dest-1 frame -> in_ready=0 and out_valid=0 for those cycles; FSM in WAIT; then 4 beats forwarded intact.
- Timeout: fifo_full[3] held high, TIMEOUT=4 -> DROP after 4 WAIT cycles; frame drained with out_valid=0; drop_cnt=1.
- Reset in FWD after 2 of 4 beats -> bus_sel=0 and out_valid=0 immediately; a next frame to dest 0 forwards correctly.
- With FRAME_DISPATCH_BCAST_EN defined, header 8'h80 -> bus_sel=4'b1111; stalls while any fifo_full bit=1.
- Stray beats in IDLE with no in_sop -> in_ready=1, out_valid=0, drop_cnt unchanged.
